dp_fsm: RTL and testbench
=========================

# dp_fsm

Control FSM for the audio datapath. A `start` pulse triggers three back-to-back memory read phases: main sample, reverb tap, chorus tap. The block then raises `tfr_ready` to tell the transfer/SPI logic that a mixed sample is available. It waits for the `transmit` handshake to assert and then deassert before it accepts a new `start`.

## Interface
Parameters:
- `READ_CYCLES`, default 1: cycles each read strobe is held, 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0). Forces the FSM to IDLE immediately, without waiting for a clock edge.
- `start`  in  1  request a new sample cycle. Level-sampled, and honoured only in IDLE.
- `transmit`  in  1  transfer in progress, driven by the downstream serializer.
- `rev_read`  out  1  read strobe for the reverb delay memory.
- `chor_read`  out  1  read strobe for the chorus delay memory.
- `main_read`  out  1  read strobe for the main sample buffer.
- `tfr_ready`  out  1  the sample is assembled and ready for transfer.

## Operation
- Moore machine. All four outputs are decoded from the state register only; no input combinationally affects an output.
- At most one output is high in any cycle.
- States and outputs:
  - IDLE: all outputs 0. If `start` = 1, go to MAIN.
  - MAIN: `main_read` = 1. Hold for READ_CYCLES cycles, then go to REV.
  - REV: `rev_read` = 1. Hold for READ_CYCLES cycles, then go to CHOR.
  - CHOR: `chor_read` = 1. Hold for READ_CYCLES cycles, then go to READY.
  - READY: `tfr_ready` = 1. If `transmit` = 1, go to XMIT; otherwise stay.
  - XMIT: all outputs 0. If `transmit` = 0, go to IDLE; otherwise stay.
- Phase counter: 4-bit down-counter, loaded with READ_CYCLES-1 on entry to MAIN, REV and CHOR. The FSM advances when the counter reaches 0.
- `start` is ignored in every state except IDLE; it does not abort or restart a sequence.
- `transmit` is ignored in IDLE, MAIN, REV and CHOR. An early-high `transmit` is therefore first acted on in READY, where the FSM stays exactly one cycle.
- If `start` is still high when the FSM returns to IDLE, a new sequence begins on the next edge.
- Illegal or unused state encodings go to IDLE on the next edge.

## Timing
- Reset (`reset` = 0): state = IDLE, counter = 0, and `rev_read` = `chor_read` = `main_read` = `tfr_ready` = 0.
  - This takes effect asynchronously, mid-sequence included.
  - Release is synchronous: the first transition occurs on the first rising edge after `reset` = 1.
- With READ_CYCLES = 1, `start` sampled high at edge N gives:
  - `main_read` high over [N, N+1)
  - `rev_read` high over [N+1, N+2)
  - `chor_read` high over [N+2, N+3)
  - `tfr_ready` high from N+3
- General latency from `start` to `tfr_ready` is 3·READ_CYCLES cycles.
- `tfr_ready` falls on the edge after `transmit` is sampled high.
- IDLE is re-entered on the edge after `transmit` is sampled low in XMIT.
- Minimum restart interval: from IDLE, the next `start` is sampled at the following edge.

## Structure
- Package `dp_pkg` holds:
  - `dp_state_t`, an enum of IDLE, MAIN, REV, CHOR, READY, XMIT, 3-bit encoding;
  - the counter width constant `DP_CNT_W` = 4.
- Single module with three processes:
  - asynchronous-reset state/counter register;
  - next-state logic;
  - output decode.
- No sub-modules.

## Test plan
- Reset: hold `reset` = 0 for 2 cycles with `start` = 1 → all outputs 0 and state IDLE. After release, `main_read` = 1 on the first edge.
- Nominal sequence: `start` pulsed 1 cycle, `transmit` rises 1 cycle later and is held 5 cycles →
  - `main_read`, `rev_read`, `chor_read` each high exactly 1 cycle, in that order;
  - `tfr_ready` high exactly 1 cycle;
  - FSM in XMIT until `transmit` falls, then IDLE.
- Back-to-back: repeat the nominal sequence immediately after return to IDLE → identical second strobe sequence, and no extra `tfr_ready` pulse.
- Late transmit: `start` pulse with `transmit` = 0 for 10 cycles → `tfr_ready` held high for all 10 cycles, falls 1 cycle after `transmit` = 1.
- Ignored inputs:
  - `start` re-pulsed during REV → no restart, order unchanged;
  - `transmit` pulsed in IDLE → no state change.
- Async reset mid-read (during CHOR, between clock edges) → `chor_read` drops immediately, and no `tfr_ready` follows.
- READ_CYCLES = 3: each read strobe is high exactly 3 cycles, and `tfr_ready` rises 9 cycles after `start` is sampled.

Source files
------------

// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dp_pkg
//  Description : Shared types and constants for the audio datapath control
//                FSM (state encoding, phase counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package dp_pkg;

    // Phase counter width; supports READ_CYCLES up to 15.
    localparam int DP_CNT_W = 4;

    // FSM state encoding (3 bits, encodings 6 and 7 unused).
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAIN  = 3'd1,
        REV   = 3'd2,
        CHOR  = 3'd3,
        READY = 3'd4,
        XMIT  = 3'd5
    } dp_state_t;

endpackage : dp_pkg
`default_nettype wire

// File: rtl/dp_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : dp_fsm
//  Description : Control FSM for the audio datapath. A start request runs
//                three read phases (main sample, reverb tap, chorus tap),
//                each READ_CYCLES long, then flags a mixed sample as ready
//                and waits for a full transmit handshake (rise, then fall)
//                before accepting a new start.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   system clock, rising-edge active
//    reset      in   asynchronous, active-low reset
//    start      in   request a new sample cycle (honoured only in IDLE)
//    transmit   in   downstream serializer busy / handshake
//    rev_read   out  reverb delay memory read strobe
//    chor_read  out  chorus delay memory read strobe
//    main_read  out  main sample buffer read strobe
//    tfr_ready  out  mixed sample ready for transfer
// ============================================================================
module dp_fsm
    import dp_pkg::*;
#(
    parameter int READ_CYCLES = 1    // cycles per read strobe, 1..15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic transmit,
    output logic rev_read,
    output logic chor_read,
    output logic main_read,
    output logic tfr_ready
);

    // Value loaded into the phase counter on entry to each read phase.
    localparam logic [DP_CNT_W-1:0] C_CNT_LOAD = DP_CNT_W'(READ_CYCLES - 1);
    localparam logic [DP_CNT_W-1:0] C_CNT_ONE  = DP_CNT_W'(1);

    dp_state_t             state_q;
    dp_state_t             state_d;
    logic [DP_CNT_W-1:0]   cnt_q;
    logic [DP_CNT_W-1:0]   cnt_d;

    // ------------------------------------------------------------------------
    // State / counter register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // Each read phase holds until the counter reaches zero, then reloads the
    // counter for the following phase so every strobe lasts READ_CYCLES.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MAIN;
                    cnt_d   = C_CNT_LOAD;
                end
            end
            MAIN: begin
                if (cnt_q == '0) begin
                    state_d = REV;
                    cnt_d   = C_CNT_LOAD;
                end else begin
                    cnt_d   = cnt_q - C_CNT_ONE;
                end
            end
            REV: begin
                if (cnt_q == '0) begin
                    state_d = CHOR;
                    cnt_d   = C_CNT_LOAD;
                end else begin
                    cnt_d   = cnt_q - C_CNT_ONE;
                end
            end
            CHOR: begin
                if (cnt_q == '0) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - C_CNT_ONE;
                end
            end
            READY: begin
                if (transmit) begin
                    state_d = XMIT;
                end
            end
            XMIT: begin
                if (!transmit) begin
                    state_d = IDLE;
                end
            end
            // Unused encodings recover to IDLE.
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode (Moore: state register only)
    // ------------------------------------------------------------------------
    always_comb begin
        main_read = 1'b0;
        rev_read  = 1'b0;
        chor_read = 1'b0;
        tfr_ready = 1'b0;
        case (state_q)
            MAIN:    main_read = 1'b1;
            REV:     rev_read  = 1'b1;
            CHOR:    chor_read = 1'b1;
            READY:   tfr_ready = 1'b1;
            default: ;
        endcase
    end

endmodule : dp_fsm
`default_nettype wire

// File: tb/tb_dp_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dp_fsm
//  Description : Directed self-checking bench for dp_fsm. Two instances:
//                READ_CYCLES = 1 (main) and READ_CYCLES = 3 (long phases).
//                Output vectors are {main_read, rev_read, chor_read,
//                tfr_ready}. Inputs change 1 time unit after a rising edge;
//                outputs are sampled at that same point, away from the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_fsm;
    import dp_pkg::*;

    logic clk;
    logic reset;
    logic start;
    logic transmit;
    logic rev_read, chor_read, main_read, tfr_ready;

    logic start3;
    logic transmit3;
    logic rev_read3, chor_read3, main_read3, tfr_ready3;

    int n_checks;
    int n_pass;

    dp_fsm #(.READ_CYCLES(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .transmit  (transmit),
        .rev_read  (rev_read),
        .chor_read (chor_read),
        .main_read (main_read),
        .tfr_ready (tfr_ready)
    );

    dp_fsm #(.READ_CYCLES(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .start     (start3),
        .transmit  (transmit3),
        .rev_read  (rev_read3),
        .chor_read (chor_read3),
        .main_read (main_read3),
        .tfr_ready (tfr_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        logic [3:0] o;
        reset    = 1'b0;
        start    = 1'b1;
        transmit = 1'b0;
        start3   = 1'b0;
        transmit3 = 1'b0;
        step();
        step();
        o = {main_read, rev_read, chor_read, tfr_ready};
        n_checks++;
        if (o !== 4'b0000) $display("FAIL reset_outputs: got %b want 0000", o);
        else n_pass++;
        n_checks++;
        if (dut.state_q !== IDLE) $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
        else n_pass++;
        n_checks++;
        if (dut.cnt_q !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q);
        else n_pass++;
        // synchronous release: start already high, so MAIN on first edge
        reset = 1'b1;
        step();
        start = 1'b0;
        o = {main_read, rev_read, chor_read, tfr_ready};
        n_checks++;
        if (o !== 4'b1000) $display("FAIL reset_release_main: got %b want 1000", o);
        else n_pass++;
        // drain the sequence back to IDLE
        step(); step(); step();     // REV, CHOR, READY
        transmit = 1'b1;
        step();                     // XMIT
        transmit = 1'b0;
        step();                     // IDLE
        n_checks++;
        if (dut.state_q !== IDLE) $display("FAIL reset_drain_idle: got %0d want %0d", dut.state_q, IDLE);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    // start pulse, transmit raised one cycle later and held for 5 cycles.
    task automatic run_nominal(input string tag);
        logic [3:0] exp_o [7];
        dp_state_t  exp_s [7];
        logic [3:0] o;
        exp_o = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        exp_s = '{MAIN, REV, CHOR, READY, XMIT, XMIT, IDLE};
        start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 0) begin
                start    = 1'b0;
                transmit = 1'b1;
            end
            if (i == 5) transmit = 1'b0;
            o = {main_read, rev_read, chor_read, tfr_ready};
            n_checks++;
            if (o !== exp_o[i]) $display("FAIL %s_out[%0d]: got %b want %b", tag, i, o, exp_o[i]);
            else n_pass++;
            n_checks++;
            if (dut.state_q !== exp_s[i]) $display("FAIL %s_state[%0d]: got %0d want %0d", tag, i, dut.state_q, exp_s[i]);
            else n_pass++;
        end
    endtask

    task automatic test_nominal();
        run_nominal("nominal");
    endtask

    task automatic test_back_to_back();
        run_nominal("b2b_first");
        run_nominal("b2b_second");
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({main_read, rev_read, chor_read, tfr_ready} !== 4'b0000)
                $display("FAIL b2b_idle_quiet[%0d]: got %b want 0000", i,
                         {main_read, rev_read, chor_read, tfr_ready});
            else n_pass++;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_late_transmit();
        logic [3:0] o;
        start    = 1'b1;
        transmit = 1'b0;
        step();                 // MAIN
        start = 1'b0;
        step(); step();         // REV, CHOR
        for (int i = 0; i < 10; i++) begin
            step();             // READY held while transmit low
            n_checks++;
            if (tfr_ready !== 1'b1) $display("FAIL late_ready_held[%0d]: got %b want 1", i, tfr_ready);
            else n_pass++;
        end
        transmit = 1'b1;
        step();
        o = {main_read, rev_read, chor_read, tfr_ready};
        n_checks++;
        if (o !== 4'b0000) $display("FAIL late_ready_fall: got %b want 0000", o);
        else n_pass++;
        transmit = 1'b0;
        step();
        n_checks++;
        if (dut.state_q !== IDLE) $display("FAIL late_back_idle: got %0d want %0d", dut.state_q, IDLE);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_ignored_inputs();
        logic [3:0] exp_o [6];
        logic [3:0] o;
        exp_o = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            case (i)
                0: start    = 1'b0;
                1: start    = 1'b1;   // re-pulse while in REV
                2: start    = 1'b0;
                3: transmit = 1'b1;
                4: transmit = 1'b0;
                default: ;
            endcase
            o = {main_read, rev_read, chor_read, tfr_ready};
            n_checks++;
            if (o !== exp_o[i]) $display("FAIL ign_start_out[%0d]: got %b want %b", i, o, exp_o[i]);
            else n_pass++;
        end
        // transmit pulsed while IDLE must not move the FSM
        transmit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (dut.state_q !== IDLE) $display("FAIL ign_transmit_idle[%0d]: got %0d want %0d", i, dut.state_q, IDLE);
            else n_pass++;
        end
        transmit = 1'b0;
        step();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_async_reset();
        start = 1'b1;
        step();                 // MAIN
        start = 1'b0;
        step();                 // REV
        step();                 // CHOR
        n_checks++;
        if (chor_read !== 1'b1) $display("FAIL arst_pre_chor: got %b want 1", chor_read);
        else n_pass++;
        #2 reset = 1'b0;        // between edges
        #1;
        n_checks++;
        if (chor_read !== 1'b0) $display("FAIL arst_chor_drop: got %b want 0", chor_read);
        else n_pass++;
        n_checks++;
        if (dut.state_q !== IDLE) $display("FAIL arst_state: got %0d want %0d", dut.state_q, IDLE);
        else n_pass++;
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({main_read, rev_read, chor_read, tfr_ready} !== 4'b0000)
                $display("FAIL arst_no_ready[%0d]: got %b want 0000", i,
                         {main_read, rev_read, chor_read, tfr_ready});
            else n_pass++;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_read_cycles3();
        logic [3:0] o;
        logic [3:0] e;
        start3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            start3 = 1'b0;
            if (i < 3)      e = 4'b1000;
            else if (i < 6) e = 4'b0100;
            else if (i < 9) e = 4'b0010;
            else            e = 4'b0001;
            o = {main_read3, rev_read3, chor_read3, tfr_ready3};
            n_checks++;
            if (o !== e) $display("FAIL rc3_out[%0d]: got %b want %b", i, o, e);
            else n_pass++;
        end
        transmit3 = 1'b1;
        step();
        n_checks++;
        if (tfr_ready3 !== 1'b0) $display("FAIL rc3_ready_fall: got %b want 0", tfr_ready3);
        else n_pass++;
        transmit3 = 1'b0;
        step();
        n_checks++;
        if (dut3.state_q !== IDLE) $display("FAIL rc3_back_idle: got %0d want %0d", dut3.state_q, IDLE);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_nominal();
        test_back_to_back();
        test_late_transmit();
        test_ignored_inputs();
        test_async_reset();
        test_read_cycles3();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule : tb_dp_fsm
`default_nettype wire
